// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: combinational decode of the incoming word into a
// control/immediate bundle, registered behind a valid/ready handshake.
module decode_stage #(
    parameter int unsigned XLEN         = 32,
    parameter bit          M_EXT        = 1'b0,
    parameter bit          HAZARD_CHECK = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_imm,
    output logic [3:0]      o_alu_op,
    output logic            o_alu_imm,
    output logic [2:0]      o_br_cond,
    output logic            o_branch,
    output logic            o_jump,
    output logic            o_reg_jump,
    output logic            o_lui,
    output logic            o_auipc,
    output logic            o_mul,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic            o_mem_unsigned,
    output logic [1:0]      o_mem_size,
    output logic            o_reg_write,
    output logic            o_trap,
    output logic            o_halt
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            alu_imm;
        logic [2:0]      br_cond;
        logic            branch;
        logic            jump;
        logic            reg_jump;
        logic            lui;
        logic            auipc;
        logic            mul;
        logic            mem_read;
        logic            mem_write;
        logic            mem_unsigned;
        logic [1:0]      mem_size;
        logic            reg_write;
        logic            trap;
        logic            halt;
    } bundle_t;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic        is_r_s, is_i_s, is_load_s, is_jalr_s, is_store_s;
    logic        is_b_s, is_lui_s, is_auipc_s, is_jal_s, is_sys_s;
    logic        known_s, r_funct7_ok_s, trap_s, mul_s;
    logic [31:0] imm32_s;
    logic [3:0]  alu_op_s;
    logic        uses_rs1_s, uses_rs2_s, hazard_s, take_in_s;
    bundle_t     dec_s;
    bundle_t     bundle_r;
    logic        valid_r;

    assign opcode_s   = i_inst[6:0];
    assign funct3_s   = i_inst[14:12];
    assign funct7_s   = i_inst[31:25];
    assign is_r_s     = (opcode_s == OP_R);
    assign is_i_s     = (opcode_s == OP_I);
    assign is_load_s  = (opcode_s == OP_LOAD);
    assign is_jalr_s  = (opcode_s == OP_JALR);
    assign is_store_s = (opcode_s == OP_STORE);
    assign is_b_s     = (opcode_s == OP_BRANCH);
    assign is_lui_s   = (opcode_s == OP_LUI);
    assign is_auipc_s = (opcode_s == OP_AUIPC);
    assign is_jal_s   = (opcode_s == OP_JAL);
    assign is_sys_s   = (opcode_s == OP_SYSTEM);
    assign known_s    = is_r_s | is_i_s | is_load_s | is_jalr_s | is_store_s |
                        is_b_s | is_lui_s | is_auipc_s | is_jal_s | is_sys_s;

    // Legal R-type funct7 values; the mul/div encoding is legal only with M enabled.
    always_comb begin
        r_funct7_ok_s = 1'b0;
        case (funct7_s)
            7'b0000000: r_funct7_ok_s = 1'b1;
            7'b0100000: r_funct7_ok_s = (funct3_s == 3'b000) || (funct3_s == 3'b101);
            7'b0000001: r_funct7_ok_s = M_EXT;
            default:    r_funct7_ok_s = 1'b0;
        endcase
    end

    assign trap_s = ~known_s | (is_r_s & ~r_funct7_ok_s);
    assign mul_s  = is_r_s & (funct7_s == 7'b0000001) & M_EXT;

    // 32-bit immediate by instruction format, sign-extended to XLEN later.
    always_comb begin
        imm32_s = 32'h0000_0000;
        case (opcode_s)
            OP_I, OP_LOAD, OP_JALR, OP_SYSTEM:
                imm32_s = {{20{i_inst[31]}}, i_inst[31:20]};
            OP_STORE:
                imm32_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            OP_BRANCH:
                imm32_s = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32_s = {i_inst[31:12], 12'h000};
            OP_JAL:
                imm32_s = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            default:
                imm32_s = 32'h0000_0000;
        endcase
    end

    // Shift-immediate forms carry the arithmetic bit only for funct3=101.
    always_comb begin
        alu_op_s = 4'b0000;
        if (is_r_s) begin
            alu_op_s = {i_inst[30], funct3_s};
        end else if (is_i_s) begin
            alu_op_s = {(funct3_s == 3'b101) ? i_inst[30] : 1'b0, funct3_s};
        end else begin
            alu_op_s = 4'b0000;
        end
    end

    // Assemble the decoded bundle for the incoming instruction.
    always_comb begin
        dec_s              = '0;
        dec_s.pc           = i_pc;
        dec_s.rs1          = i_inst[19:15];
        dec_s.rs2          = i_inst[24:20];
        dec_s.rd           = i_inst[11:7];
        dec_s.imm          = XLEN'($signed(imm32_s));
        dec_s.alu_op       = alu_op_s;
        dec_s.alu_imm      = ~(is_r_s | is_b_s);
        dec_s.br_cond      = is_b_s ? funct3_s : 3'b000;
        dec_s.branch       = is_b_s;
        dec_s.jump         = is_jal_s | is_jalr_s;
        dec_s.reg_jump     = is_jalr_s;
        dec_s.lui          = is_lui_s;
        dec_s.auipc        = is_auipc_s;
        dec_s.mul          = mul_s & ~trap_s;
        dec_s.mem_read     = is_load_s & ~trap_s;
        dec_s.mem_write    = is_store_s & ~trap_s;
        dec_s.mem_unsigned = is_load_s & funct3_s[2];
        dec_s.mem_size     = (is_load_s | is_store_s) ? funct3_s[1:0] : 2'b00;
        dec_s.reg_write    = ~(is_store_s | is_b_s | trap_s | is_sys_s);
        dec_s.trap         = trap_s;
        dec_s.halt         = is_sys_s;
    end

    assign uses_rs1_s = is_r_s | is_i_s | is_load_s | is_jalr_s | is_store_s | is_b_s;
    assign uses_rs2_s = is_r_s | is_store_s | is_b_s;
    // A held load whose destination feeds the incoming instruction forces one bubble.
    assign hazard_s   = HAZARD_CHECK && i_in_valid && valid_r && bundle_r.mem_read &&
                        (bundle_r.rd != 5'd0) &&
                        ((uses_rs1_s && (i_inst[19:15] == bundle_r.rd)) ||
                         (uses_rs2_s && (i_inst[24:20] == bundle_r.rd)));
    assign o_in_ready = ~hazard_s & (~valid_r | i_out_ready);
    assign take_in_s  = i_in_valid & o_in_ready;

    // Bundle register: flush beats a transfer in, which beats draining to a bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_r  <= 1'b0;
            bundle_r <= '0;
        end else if (i_flush) begin
            valid_r  <= 1'b0;
        end else if (take_in_s) begin
            valid_r  <= 1'b1;
            bundle_r <= dec_s;
        end else if (i_out_ready) begin
            valid_r  <= 1'b0;
        end
    end

    assign o_out_valid    = valid_r;
    assign o_pc           = bundle_r.pc;
    assign o_rs1          = bundle_r.rs1;
    assign o_rs2          = bundle_r.rs2;
    assign o_rd           = bundle_r.rd;
    assign o_imm          = bundle_r.imm;
    assign o_alu_op       = bundle_r.alu_op;
    assign o_alu_imm      = bundle_r.alu_imm;
    assign o_br_cond      = bundle_r.br_cond;
    assign o_branch       = bundle_r.branch;
    assign o_jump         = bundle_r.jump;
    assign o_reg_jump     = bundle_r.reg_jump;
    assign o_lui          = bundle_r.lui;
    assign o_auipc        = bundle_r.auipc;
    assign o_mul          = bundle_r.mul;
    assign o_mem_read     = bundle_r.mem_read;
    assign o_mem_write    = bundle_r.mem_write;
    assign o_mem_unsigned = bundle_r.mem_unsigned;
    assign o_mem_size     = bundle_r.mem_size;
    assign o_reg_write    = bundle_r.reg_write;
    assign o_trap         = bundle_r.trap;
    assign o_halt         = bundle_r.halt;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two configurations (RV32/no-M/hazard, RV64/M/no-hazard)
// driven in lockstep and compared each cycle against an arithmetic reference model.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] inst = 32'h0;
    logic [63:0] pc = 64'h0;

    logic        rdy0, rdy1, vld0, vld1;
    logic [31:0] pc0, imm0;
    logic [63:0] pc1, imm1;
    logic [14:0] regs0, regs1;
    logic [21:0] ctrl0, ctrl1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [14:0] regs;
        logic [63:0] imm;
        logic [21:0] ctrl;
    } exp_t;

    exp_t        mb [2];
    bit          mv [2];
    bit          mext_c [2] = '{1'b0, 1'b1};
    bit          haz_c  [2] = '{1'b1, 1'b0};
    logic [63:0] mask_c [2] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .M_EXT(1'b0), .HAZARD_CHECK(1'b1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy0),
        .i_inst(inst), .i_pc(pc[31:0]), .i_flush(flush), .o_out_valid(vld0),
        .i_out_ready(out_ready), .o_pc(pc0),
        .o_rs1(regs0[14:10]), .o_rs2(regs0[9:5]), .o_rd(regs0[4:0]), .o_imm(imm0),
        .o_alu_op(ctrl0[21:18]), .o_alu_imm(ctrl0[17]), .o_br_cond(ctrl0[16:14]),
        .o_branch(ctrl0[13]), .o_jump(ctrl0[12]), .o_reg_jump(ctrl0[11]),
        .o_lui(ctrl0[10]), .o_auipc(ctrl0[9]), .o_mul(ctrl0[8]),
        .o_mem_read(ctrl0[7]), .o_mem_write(ctrl0[6]), .o_mem_unsigned(ctrl0[5]),
        .o_mem_size(ctrl0[4:3]), .o_reg_write(ctrl0[2]), .o_trap(ctrl0[1]), .o_halt(ctrl0[0])
    );

    decode_stage #(.XLEN(64), .M_EXT(1'b1), .HAZARD_CHECK(1'b0)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy1),
        .i_inst(inst), .i_pc(pc), .i_flush(flush), .o_out_valid(vld1),
        .i_out_ready(out_ready), .o_pc(pc1),
        .o_rs1(regs1[14:10]), .o_rs2(regs1[9:5]), .o_rd(regs1[4:0]), .o_imm(imm1),
        .o_alu_op(ctrl1[21:18]), .o_alu_imm(ctrl1[17]), .o_br_cond(ctrl1[16:14]),
        .o_branch(ctrl1[13]), .o_jump(ctrl1[12]), .o_reg_jump(ctrl1[11]),
        .o_lui(ctrl1[10]), .o_auipc(ctrl1[9]), .o_mul(ctrl1[8]),
        .o_mem_read(ctrl1[7]), .o_mem_write(ctrl1[6]), .o_mem_unsigned(ctrl1[5]),
        .o_mem_size(ctrl1[4:3]), .o_reg_write(ctrl1[2]), .o_trap(ctrl1[1]), .o_halt(ctrl1[0])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the ISA field layout, immediates by signed arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] a, input bit m_ext);
        exp_t   e;
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        longint s = longint'($signed(w));
        longint imm = 0;
        bit r = (op == 7'h33), ia = (op == 7'h13), ld = (op == 7'h03), jr = (op == 7'h67);
        bit st = (op == 7'h23), br = (op == 7'h63), lu = (op == 7'h37), au = (op == 7'h17);
        bit jl = (op == 7'h6f), sy = (op == 7'h73);
        bit known = r | ia | ld | jr | st | br | lu | au | jl | sy;
        bit r_ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'h01 && m_ext);
        bit trap = !known || (r && !r_ok);
        bit mul = r && f7 == 7'h01 && m_ext;
        logic [3:0] aop = 4'd0;
        if (ia || ld || jr || sy) imm = s >>> 20;
        else if (st) imm = 32 * (s >>> 25) + longint'(w[11:7]);
        else if (br) imm = -4096 * longint'(w[31]) + 2048 * longint'(w[7]) + 32 * longint'(w[30:25]) + 2 * longint'(w[11:8]);
        else if (lu || au) imm = s & longint'(-4096);
        else if (jl) imm = -1048576 * longint'(w[31]) + 4096 * longint'(w[19:12]) + 2048 * longint'(w[20]) + 2 * longint'(w[30:21]);
        if (r) aop = {w[30], f3};
        else if (ia) aop = {(f3 == 3'd5) & w[30], f3};
        e.pc   = a;
        e.regs = {w[19:15], w[24:20], w[11:7]};
        e.imm  = imm;
        e.ctrl = {aop, !(r || br), br ? f3 : 3'd0, br, jl | jr, jr, lu, au, mul,
                  ld, st, ld & f3[2], (ld | st) ? f3[1:0] : 2'd0,
                  !(st || br || trap || sy), trap, sy};
        return e;
    endfunction

    function automatic bit uses1(input logic [31:0] w);
        return w[6:0] inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63};
    endfunction

    function automatic bit uses2(input logic [31:0] w);
        return w[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic exp_t obs_of(input int k);
        exp_t o;
        if (k == 0) begin
            o.pc = {32'h0, pc0}; o.regs = regs0; o.imm = {32'h0, imm0}; o.ctrl = ctrl0;
        end else begin
            o.pc = pc1; o.regs = regs1; o.imm = imm1; o.ctrl = ctrl1;
        end
        return o;
    endfunction

    // One clock: check ready before the edge, advance the model, check outputs after.
    task automatic step();
        exp_t d, o;
        bit   hz, r, held_ld;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            d = ref_decode(inst, pc & mask_c[k], mext_c[k]);
            held_ld = mv[k] && mb[k].ctrl[7] && (mb[k].regs[4:0] != 5'd0);
            hz = haz_c[k] && in_valid && held_ld &&
                 ((uses1(inst) && inst[19:15] == mb[k].regs[4:0]) ||
                  (uses2(inst) && inst[24:20] == mb[k].regs[4:0]));
            r = !hz && (!mv[k] || out_ready);
            check($sformatf("d%0d_in_ready", k), 64'((k == 0) ? rdy0 : rdy1), 64'(r));
            if (flush) mv[k] = 1'b0;
            else if (in_valid && r) begin mv[k] = 1'b1; mb[k] = d; end
            else if (out_ready) mv[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            o = obs_of(k);
            check($sformatf("d%0d_valid", k), 64'((k == 0) ? vld0 : vld1), 64'(mv[k]));
            if (mv[k]) begin
                check($sformatf("d%0d_pc", k), o.pc, mb[k].pc);
                check($sformatf("d%0d_regs", k), 64'(o.regs), 64'(mb[k].regs));
                check($sformatf("d%0d_imm", k), o.imm, mb[k].imm & mask_c[k]);
                check($sformatf("d%0d_ctrl", k), 64'(o.ctrl), 64'(mb[k].ctrl));
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_d0_bundle"}, 64'({vld0, ctrl0, regs0}), 64'd0);
        check({tag, "_d0_pc_imm"}, {pc0, imm0}, 64'd0);
        check({tag, "_d1_bundle"}, 64'({vld1, ctrl1, regs1}), 64'd0);
        check({tag, "_d1_pc"}, pc1, 64'd0);
        check({tag, "_d1_imm"}, imm1, 64'd0);
        check({tag, "_ready"}, 64'({rdy0, rdy1}), 64'd3);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w = $urandom;
        logic [6:0]  ops [12];
        int          sel = $urandom_range(0, 13);
        ops = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73, 7'h33};
        if (sel < 12) w[6:0] = ops[sel];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        if (w[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    initial begin
        mv[0] = 1'b0; mv[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        // addi x1,x0,5
        in_valid = 1'b1; out_ready = 1'b1; inst = 32'h0050_0093; pc = 64'h100;
        step();
        check("addi_imm", 64'(imm0), 64'd5);
        check("addi_rd", 64'(regs0[4:0]), 64'd1);

        // lw x2,0(x1) then dependent add x3,x2,x2
        inst = 32'h0000_A103; pc = 64'h104;
        step();
        inst = 32'h0021_01B3; pc = 64'h108;
        step();
        check("bubble_valid_d0", 64'(vld0), 64'd0);
        check("nohaz_pc_d1", pc1, 64'h108);
        step();
        check("after_bubble_pc_d0", 64'(pc0), 64'h108);

        // mul x3,x1,x2
        inst = 32'h0220_81B3; pc = 64'h10C;
        step();
        check("mul_d0_trap_rw", 64'({ctrl0[1], ctrl0[2], ctrl0[8]}), 64'b100);
        check("mul_d1_mul_trap_rw", 64'({ctrl1[8], ctrl1[1], ctrl1[2]}), 64'b101);

        // beq x1,x2,-4
        inst = 32'hFE20_8EE3; pc = 64'h110;
        step();
        check("beq_imm_d0", 64'(imm0), 64'h0000_0000_FFFF_FFFC);
        check("beq_imm_d1", imm1, 64'hFFFF_FFFF_FFFF_FFFC);

        // Backpressure for three cycles, then flush with a valid incoming word
        out_ready = 1'b0; inst = 32'h0050_0093; pc = 64'h114;
        repeat (3) step();
        check("held_pc_d0", 64'(pc0), 64'h110);
        check("held_branch_d1", 64'(ctrl1[13]), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", 64'({vld0, vld1}), 64'd0);

        // Random traffic with an asynchronous reset partway through
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 99) < 75);
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 3);
            inst      = rand_inst();
            pc        = {$urandom, $urandom};
            if (i == 700) begin
                in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
                #2 rst = 1'b1;
                #1 check_reset("async_reset");
                mv[0] = 1'b0; mv[1] = 1'b0;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I instruction-decode pipeline stage sitting between fetch and execute. Accepts one instruction per cycle over a valid/ready handshake and produces a fully decoded control/immediate bundle one cycle later. Adds optional M-extension decode, load-use hazard bubble insertion, flush and illegal-encoding trapping on top of purely combinational decode.

## Interface
- XLEN, 32, datapath width (32 or 64); immediate and PC are XLEN wide, instruction is always 32 bits
- M_EXT, 0, 1 = decode R-type funct7=0000001 as mul/div; 0 = treat as illegal
- HAZARD_CHECK, 1, 1 = insert load-use bubble; 0 = never stall for hazards

- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_in_valid  in  1  upstream instruction valid
- o_in_ready  out  1  stage can accept (combinational)
- i_inst  in  32  instruction word
- i_pc  in  XLEN  instruction address
- i_flush  in  1  discard held and incoming instruction
- o_out_valid  out  1  decoded bundle valid
- i_out_ready  in  1  downstream accepts bundle
- o_pc  out  XLEN  registered i_pc
- o_rs1, o_rs2, o_rd  out  5 each  register addresses (inst[19:15], [24:20], [11:7])
- o_imm  out  XLEN  sign-extended immediate (I/S/B/U/J by format; 0 for R)
- o_alu_op  out  4  {arith/sub bit, funct3}
- o_alu_imm  out  1  ALU operand B is immediate
- o_br_cond  out  3  funct3 for branches
- o_branch, o_jump, o_reg_jump, o_lui, o_auipc, o_mul  out  1 each
- o_mem_read, o_mem_write, o_mem_unsigned  out  1 each
- o_mem_size  out  2  funct3[1:0]
- o_reg_write  out  1  writes rd
- o_trap  out  1  illegal encoding
- o_halt  out  1  opcode 1110011

## Operation
- Formats: R 0110011; I-arith 0010011; load 0000011; JALR 1100111; S 0100011; B 1100011; LUI 0110111; AUIPC 0010111; JAL 1101111; SYSTEM 1110011 sets o_halt.
- o_alu_op: R → {inst[30], funct3}; I-arith → {inst[30] only if funct3=101 else 0, funct3}; all others 4'b0000.
- o_alu_imm = ~(R | B). o_reg_write = ~(S | B | trap | halt). o_jump = JAL|JALR; o_reg_jump = JALR. o_mem_unsigned = load & funct3[2].
- Trap: unknown opcode, or R-type funct7 not in {0000000, 0100000 with funct3∈{000,101}, 0000001 when M_EXT=1}. Trapped bundle passes through with o_trap=1, o_reg_write=0, o_mem_read=0, o_mem_write=0, o_mul=0.
- o_mul = R & funct7=0000001 & M_EXT.
- Hazard (HAZARD_CHECK=1): held bundle is o_out_valid & o_mem_read & o_rd≠0, and incoming valid instruction uses a matching source. rs1 used by all formats except LUI/AUIPC/JAL/SYSTEM; rs2 used by R/S/B only.
- o_in_ready = ~hazard & (~o_out_valid | i_out_ready).
- Transfer in: i_in_valid & o_in_ready → bundle register loads, o_out_valid←1.
- Transfer out without new transfer in → o_out_valid←0 (bubble on hazard).

## Timing
- Reset: all outputs registered 0 (o_out_valid=0); o_in_ready=1 after reset.
- Latency 1 cycle; throughput 1/cycle when no hazard and no backpressure.
- Load-use: exactly one bubble cycle between load and dependent instruction.
- Backpressure: o_out_valid=1 & i_out_ready=0 → all outputs held stable, o_in_ready=0.
- i_flush: next edge o_out_valid←0; any transfer in that cycle discarded; flush dominates hazard and input.
- Async reset mid-stream clears bundle immediately regardless of handshake state.

## Test plan
- addi x1,x0,5 (0x00500093) at pc 0x100 → next cycle o_out_valid=1, o_rd=1, o_imm=5, o_alu_op=0000, o_alu_imm=1, o_reg_write=1, o_pc=0x100.
- lw x2,0(x1) (0x0000A103) then add x3,x2,x2 (0x002101B3), i_out_ready=1 → o_in_ready=0 one cycle, one bubble (o_out_valid=0), add emitted next; HAZARD_CHECK=0 → no bubble.
- mul x3,x1,x2 (0x022081B3) → M_EXT=0: o_trap=1, o_reg_write=0; M_EXT=1: o_mul=1, o_trap=0, o_reg_write=1.
- beq x1,x2,-4 (0xFE208EE3) → o_branch=1, o_imm=0xFFFFFFFC (XLEN=32) / 0xFFFFFFFFFFFFFFFC (XLEN=64), o_reg_write=0, o_br_cond=000.
- i_out_ready=0 for 3 cycles with bundle held → outputs unchanged, o_in_ready=0; then i_flush with i_in_valid=1 → o_out_valid=0 next cycle, incoming dropped.
- Assert i_rst asynchronously mid-stream → o_out_valid and all outputs 0 before next edge; o_in_ready=1.
